// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise logic unit with eight ops and valid/ready on both sides.
// Accumulate mode folds a multi-beat packet into a single result beat.
module bitwise_logic_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_beats
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc_p0, acc_next;
  logic [CNT_W-1:0] cnt_p0, cnt_next;
  logic             beat;
  logic             push;
  logic [WIDTH-1:0] beat_res;
  logic [WIDTH-1:0] fold_res;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] res_beats;

  function automatic logic [WIDTH-1:0] bit_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (op)
      3'b000:  bit_op = x & y;
      3'b001:  bit_op = x | y;
      3'b010:  bit_op = x ^ y;
      3'b011:  bit_op = ~(x ^ y);
      3'b100:  bit_op = ~(x & y);
      3'b101:  bit_op = ~(x | y);
      3'b110:  bit_op = x & ~y;
      default: bit_op = x;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  assign in_ready = ~reset & (~out_valid | out_ready);
  assign beat     = in_valid & in_ready;
  assign beat_res = bit_op(in_op, p, q);
  // The running accumulator is combined with this beat's result using the same op.
  assign fold_res = bit_op(in_op, acc_p0, beat_res);

  always_comb begin
    state_next = state;
    acc_next   = acc_p0;
    cnt_next   = cnt_p0;
    push       = 1'b0;
    res        = beat_res;
    res_beats  = CNT_W'(1);
    case (state)
      IDLE: begin
        if (beat) begin
          if (!in_acc || in_last) begin
            push = 1'b1;
          end else begin
            acc_next   = beat_res;
            cnt_next   = CNT_W'(1);
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          if (in_last) begin
            push       = 1'b1;
            res        = fold_res;
            res_beats  = sat_inc(cnt_p0);
            state_next = IDLE;
          end else begin
            acc_next = fold_res;
            cnt_next = sat_inc(cnt_p0);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0 -> output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc_p0    <= '0;
      cnt_p0    <= '0;
      out_valid <= 1'b0;
      s         <= '0;
      out_zero  <= 1'b0;
      out_beats <= '0;
    end else begin
      state  <= state_next;
      acc_p0 <= acc_next;
      cnt_p0 <= cnt_next;
      if (push) begin
        out_valid <= 1'b1;
        s         <= res;
        out_zero  <= (res == '0);
        out_beats <= res_beats;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe: directed scenarios plus randomized traffic
// checked against a packet-list reference model.
module tb_bitwise_logic_pipe;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_acc, in_last;
  logic [2:0]    in_op;
  logic [W-1:0]  p, q, s;
  logic          out_valid, out_ready, out_zero;
  logic [CW-1:0] out_beats;

  logic          reset_w, in_valid_w, in_ready_w, in_acc_w, in_last_w;
  logic [2:0]    in_op_w;
  logic [7:0]    p_w, q_w, s_w;
  logic          out_valid_w, out_ready_w, out_zero_w;
  logic [1:0]    out_beats_w;

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_acc(in_acc), .in_last(in_last), .p(p), .q(q),
    .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .out_zero(out_zero), .out_beats(out_beats)
  );

  bitwise_logic_pipe #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_op(in_op_w), .in_acc(in_acc_w), .in_last(in_last_w), .p(p_w), .q(q_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .s(s_w),
    .out_zero(out_zero_w), .out_beats(out_beats_w)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a list of beats in the open packet plus the output register.
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } beat_t;

  beat_t        pkt[$];
  bit           m_valid = 1'b0;
  logic [W-1:0] m_s     = '0;
  bit           m_zero  = 1'b0;
  int           m_beats = 0;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a ^ b);
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic cycle(input bit v, input logic [2:0] op, input bit acc, input bit last,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ordy, input bit rst);
    bit           exp_rdy;
    bit           pushed;
    logic [W-1:0] r;
    int           nb;
    reset     = rst;
    in_valid  = v;
    in_op     = op;
    in_acc    = acc;
    in_last   = last;
    p         = a;
    q         = b;
    out_ready = ordy;
    #1;
    exp_rdy = !rst && (!m_valid || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    pushed = 1'b0;
    r      = '0;
    nb     = 0;
    if (rst) begin
      m_valid = 1'b0;
      m_s     = '0;
      m_zero  = 1'b0;
      m_beats = 0;
      pkt.delete();
    end else begin
      if (v && exp_rdy) begin
        if (pkt.size() == 0 && (!acc || last)) begin
          r      = ref_op(op, a, b);
          nb     = 1;
          pushed = 1'b1;
        end else begin
          pkt.push_back('{op, a, b});
          if (pkt.size() > 1 && last) begin
            r = ref_op(pkt[0].op, pkt[0].a, pkt[0].b);
            for (int i = 1; i < pkt.size(); i++)
              r = ref_op(pkt[i].op, r, ref_op(pkt[i].op, pkt[i].a, pkt[i].b));
            nb     = (pkt.size() > MAXC) ? MAXC : pkt.size();
            pushed = 1'b1;
            pkt.delete();
          end
        end
      end
      if (pushed) begin
        m_valid = 1'b1;
        m_s     = r;
        m_zero  = (r == '0);
        m_beats = nb;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("s", 32'(s), 32'(m_s));
    chk("out_zero", 32'(out_zero), 32'(m_zero));
    chk("out_beats", 32'(out_beats), 32'(m_beats));
  endtask

  task automatic cycle_w(input bit v, input logic [2:0] op, input bit acc, input bit last,
                         input logic [7:0] a, input logic [7:0] b, input bit rst);
    reset_w     = rst;
    in_valid_w  = v;
    in_op_w     = op;
    in_acc_w    = acc;
    in_last_w   = last;
    p_w         = a;
    q_w         = b;
    out_ready_w = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_w = 1'b1; in_valid_w = 1'b0; in_op_w = '0; in_acc_w = 1'b0; in_last_w = 1'b0;
    p_w = '0; q_w = '0; out_ready_w = 1'b1;

    // Reset state
    cycle(0, 3'd0, 0, 0, 4'h0, 4'h0, 1, 1);
    cycle(0, 3'd0, 0, 0, 4'h0, 4'h0, 1, 1);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_s", 32'(s), 32'd0);

    // Single XNOR, latency 1
    cycle(1, 3'b011, 0, 0, 4'b0011, 4'b0101, 1, 0);
    chk("xnor_s", 32'(s), 32'b1001);
    chk("xnor_beats", 32'(out_beats), 32'd1);

    // Backpressure: result held, no acceptance
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3'b000, 0, 0, 4'hF, 4'hF, 0, 0);
      chk("bp_s_hold", 32'(s), 32'b1001);
    end
    cycle(0, 3'b000, 0, 0, 4'h0, 4'h0, 1, 0);
    chk("bp_pop_valid", 32'(out_valid), 32'd0);

    // Accumulate packet of three beats
    cycle(1, 3'b010, 1, 0, 4'b0011, 4'b0101, 1, 0);
    chk("acc_no_out", 32'(out_valid), 32'd0);
    cycle(1, 3'b010, 0, 0, 4'b0000, 4'b1111, 1, 0);
    cycle(1, 3'b000, 0, 1, 4'b1111, 4'b1010, 1, 0);
    chk("acc_s", 32'(s), 32'b1000);
    chk("acc_beats", 32'(out_beats), 32'd3);

    // Zero flag, back-to-back with no bubble
    cycle(1, 3'b000, 0, 0, 4'b1010, 4'b0101, 1, 0);
    chk("and_zero", 32'(out_zero), 32'd1);
    cycle(1, 3'b001, 0, 0, 4'b1010, 4'b0101, 1, 0);
    chk("or_s", 32'(s), 32'hF);
    chk("or_zero", 32'(out_zero), 32'd0);
    chk("or_valid", 32'(out_valid), 32'd1);

    // Reset in the middle of a packet
    cycle(1, 3'b010, 1, 0, 4'h1, 4'h2, 1, 0);
    cycle(1, 3'b010, 0, 0, 4'h4, 4'h8, 1, 0);
    cycle(0, 3'b000, 0, 0, 4'h0, 4'h0, 1, 1);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_s", 32'(s), 32'd0);
    cycle(1, 3'b010, 0, 0, 4'b0110, 4'b0011, 1, 0);
    chk("after_rst_s", 32'(s), 32'b0101);
    chk("after_rst_beats", 32'(out_beats), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
            W'($urandom), W'($urandom), bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 60) == 0));
    end

    // Wide instance: NAND and saturating beat counter
    cycle_w(0, 3'd0, 0, 0, 8'h00, 8'h00, 1);
    cycle_w(1, 3'b100, 0, 0, 8'hF0, 8'h3C, 0);
    chk("w_nand_s", 32'(s_w), 32'hCF);
    chk("w_nand_beats", 32'(out_beats_w), 32'd1);
    cycle_w(1, 3'b001, 1, 0, 8'h01, 8'h00, 0);
    cycle_w(1, 3'b001, 0, 0, 8'h02, 8'h00, 0);
    cycle_w(1, 3'b001, 0, 0, 8'h04, 8'h00, 0);
    cycle_w(1, 3'b001, 0, 0, 8'h08, 8'h00, 0);
    chk("w_acc_pending", 32'(out_valid_w), 32'd0);
    cycle_w(1, 3'b001, 0, 1, 8'h10, 8'h00, 0);
    chk("w_acc_valid", 32'(out_valid_w), 32'd1);
    chk("w_acc_s", 32'(s_w), 32'h1F);
    chk("w_acc_beats_sat", 32'(out_beats_w), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
